// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline hazard logic.
//   hz_cause_t  : reason the ID stage is held or squashed (3 bits)
//   mdu_state_t : occupancy state of the multi-cycle multiply/divide unit
package cpu_types_pkg;

    typedef enum logic [2:0] {
        HZ_NONE  = 3'd0,
        HZ_RAW   = 3'd1,
        HZ_WAW   = 3'd2,
        HZ_MDU   = 3'd3,
        HZ_MEM   = 3'd4,
        HZ_FLUSH = 3'd5
    } hz_cause_t;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_t;

endpackage

// File: rtl/hu_scoreboard.sv
// Per-register latency counter bank for the hazard unit.
//   CLK, RST  : clock, async active-high reset (clears every counter)
//   dec_en    : decrement every nonzero counter by one this cycle
//   set_en    : load counter set_idx with set_val (wins over the decrement)
//   set_idx   : register index to load; index 0 is never loaded
//   set_val   : value to load
//   rd_idx    : register index whose count is presented on rd_cnt
//   rd_cnt    : current count of register rd_idx
//   busy_vec  : bit r set while counter r is nonzero
module hu_scoreboard #(
    parameter int unsigned NREGS = 32,
    parameter int unsigned REG_W = 5,
    parameter int unsigned LAT_W = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             dec_en,
    input  logic             set_en,
    input  logic [REG_W-1:0] set_idx,
    input  logic [LAT_W-1:0] set_val,
    input  logic [REG_W-1:0] rd_idx,
    output logic [LAT_W-1:0] rd_cnt,
    output logic [NREGS-1:0] busy_vec
);

    logic [LAT_W-1:0] cnt [NREGS];

    // cnt[0] is only ever cleared, so register 0 can never look pending.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int unsigned r = 1; r < NREGS; r++) begin
                if (set_en && set_idx == REG_W'(r)) begin
                    cnt[r] <= set_val;
                end else if (dec_en && cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - LAT_W'(1);
                end
            end
        end
    end

    always_comb begin
        busy_vec = '0;
        for (int unsigned r = 0; r < NREGS; r++) begin
            busy_vec[r] = (cnt[r] != '0);
        end
    end

    assign rd_cnt = cnt[rd_idx];

endmodule

// File: rtl/scoreboard_hazard_unit.sv
// Hazard unit for the 5-stage pipeline, sitting beside decode.
// Tracks per-register result latency, multi-cycle MDU occupancy, memory-wait
// freezes and mispredict flushes (deferred while frozen), and drives the
// PC / IF-ID stall and IF-ID / ID-EX flush controls.
//   CLK, RST                  : clock, async active-high reset
//   id_valid                  : valid instruction in ID
//   id_rs, id_rt              : source registers
//   id_rs_used, id_rt_used    : source actually read
//   id_dest, id_wen           : destination register and its write enable
//   id_lat                    : cycles until forwardable (0 or >MAX_LAT -> MAX_LAT)
//   id_mdu                    : instruction uses the multi-cycle MDU
//   mdu_done                  : MDU result ready (1-cycle pulse)
//   ex_mispredict             : branch in EX resolved mispredicted
//   imem_wait, dmem_wait      : memory not ready (freeze the pipeline)
//   stall_PC, stall_IFID      : hold PC / IF-ID latch
//   flush_IFID, flush_IDEX    : zero IF-ID latch / bubble into ID-EX
//   issue                     : ID instruction advances this cycle
//   busy_vec                  : per-register pending result
//   stall_cause               : highest-priority active cause (hz_cause_t)
module scoreboard_hazard_unit
    import cpu_types_pkg::*;
#(
    parameter int unsigned NREGS   = 32,
    parameter int unsigned REG_W   = 5,
    parameter int unsigned MAX_LAT = 4,
    parameter int unsigned LAT_W   = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_wen,
    input  logic [LAT_W-1:0] id_lat,
    input  logic             id_mdu,
    input  logic             mdu_done,
    input  logic             ex_mispredict,
    input  logic             imem_wait,
    input  logic             dmem_wait,
    output logic             stall_PC,
    output logic             stall_IFID,
    output logic             flush_IFID,
    output logic             flush_IDEX,
    output logic             issue,
    output logic [NREGS-1:0] busy_vec,
    output logic [2:0]       stall_cause
);

    mdu_state_t       mdu_state, mdu_state_next;
    logic [REG_W-1:0] mdu_dest, mdu_dest_next;
    logic             pend_flush;

    logic             freeze;
    logic             flush_now;
    logic [LAT_W-1:0] lat_eff;
    logic [LAT_W-1:0] sb_set_val;
    logic             sb_set_en;
    logic [LAT_W-1:0] sb_rd_cnt;
    logic [NREGS-1:0] sb_busy;
    logic [NREGS-1:0] mdu_bits;
    logic [NREGS-1:0] busy_int;
    logic             raw_hz, waw_hz, mdu_hz, any_hz;
    logic             issue_int;
    hz_cause_t        cause;

    assign freeze    = imem_wait | dmem_wait;
    assign flush_now = (ex_mispredict | pend_flush) & ~freeze;

    always_comb begin
        if (id_lat == '0 || id_lat > LAT_W'(MAX_LAT)) begin
            lat_eff = LAT_W'(MAX_LAT);
        end else begin
            lat_eff = id_lat;
        end
    end

    // The counter holds the number of *further* cycles until forwardable, so a
    // latency-1 op loads 0 and its consumer in the next cycle does not stall.
    assign sb_set_val = lat_eff - LAT_W'(1);
    assign sb_set_en  = issue_int & id_wen & (id_dest != '0) & ~id_mdu;

    hu_scoreboard #(
        .NREGS (NREGS),
        .REG_W (REG_W),
        .LAT_W (LAT_W)
    ) u_sb (
        .CLK      (CLK),
        .RST      (RST),
        .dec_en   (~freeze),
        .set_en   (sb_set_en),
        .set_idx  (id_dest),
        .set_val  (sb_set_val),
        .rd_idx   (id_dest),
        .rd_cnt   (sb_rd_cnt),
        .busy_vec (sb_busy)
    );

    always_comb begin
        mdu_bits = '0;
        if (mdu_state == MDU_BUSY && mdu_dest != '0) begin
            mdu_bits[mdu_dest] = 1'b1;
        end
    end

    assign busy_int = sb_busy | mdu_bits;

    // Hazard detection only matters for a valid ID instruction.
    assign raw_hz = id_valid &
                    ((id_rs_used & (id_rs != '0) & busy_int[id_rs]) |
                     (id_rt_used & (id_rt != '0) & busy_int[id_rt]));
    // WAW: an older write to the same register would land after this one.
    assign waw_hz = id_valid & id_wen & (id_dest != '0) &
                    ((sb_rd_cnt >= lat_eff) ||
                     (mdu_state == MDU_BUSY && id_dest == mdu_dest));
    assign mdu_hz = id_valid & id_mdu & (mdu_state == MDU_BUSY) & ~mdu_done;
    assign any_hz = raw_hz | waw_hz | mdu_hz;

    // State register: MDU FSM, its destination and the deferred flush.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mdu_state  <= MDU_IDLE;
            mdu_dest   <= '0;
            pend_flush <= 1'b0;
        end else begin
            mdu_state <= mdu_state_next;
            mdu_dest  <= mdu_dest_next;
            if (freeze) begin
                if (ex_mispredict) begin
                    pend_flush <= 1'b1;
                end
            end else begin
                pend_flush <= 1'b0;
            end
        end
    end

    // Next state: mdu_done is honoured regardless of freeze; a new MDU issue in
    // the done cycle keeps the unit busy with the new destination.
    always_comb begin
        mdu_state_next = mdu_state;
        mdu_dest_next  = mdu_dest;
        case (mdu_state)
            MDU_IDLE: begin
                if (issue_int && id_mdu) begin
                    mdu_state_next = MDU_BUSY;
                    mdu_dest_next  = id_wen ? id_dest : '0;
                end
            end
            MDU_BUSY: begin
                if (issue_int && id_mdu) begin
                    mdu_dest_next = id_wen ? id_dest : '0;
                end else if (mdu_done) begin
                    mdu_state_next = MDU_IDLE;
                end
            end
            default: mdu_state_next = MDU_IDLE;
        endcase
    end

    // Outputs, priority MEM > FLUSH > MDU > WAW > RAW.
    always_comb begin
        stall_PC   = 1'b0;
        stall_IFID = 1'b0;
        flush_IFID = 1'b0;
        flush_IDEX = 1'b0;
        issue_int  = 1'b0;
        cause      = HZ_NONE;
        if (RST) begin
            cause = HZ_NONE;
        end else if (freeze) begin
            stall_PC   = 1'b1;
            stall_IFID = 1'b1;
            cause      = HZ_MEM;
        end else if (flush_now) begin
            flush_IFID = 1'b1;
            flush_IDEX = 1'b1;
            cause      = HZ_FLUSH;
        end else if (any_hz) begin
            stall_PC   = 1'b1;
            stall_IFID = 1'b1;
            flush_IDEX = 1'b1;
            if (mdu_hz) begin
                cause = HZ_MDU;
            end else if (waw_hz) begin
                cause = HZ_WAW;
            end else begin
                cause = HZ_RAW;
            end
        end else begin
            issue_int = id_valid;
        end
    end

    assign issue       = issue_int;
    assign stall_cause = cause;
    assign busy_vec    = RST ? '0 : busy_int;

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
module tb_scoreboard_hazard_unit;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_dest;
    logic        id_rs_used, id_rt_used, id_wen, id_mdu;
    logic [2:0]  id_lat;
    logic        mdu_done, ex_mispredict, imem_wait, dmem_wait;
    logic        stall_PC, stall_IFID, flush_IFID, flush_IDEX, issue;
    logic [31:0] busy_vec;
    logic [2:0]  stall_cause;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    scoreboard_hazard_unit #(
        .NREGS   (32),
        .REG_W   (5),
        .MAX_LAT (4),
        .LAT_W   (3)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .id_valid      (id_valid),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_rs_used    (id_rs_used),
        .id_rt_used    (id_rt_used),
        .id_dest       (id_dest),
        .id_wen        (id_wen),
        .id_lat        (id_lat),
        .id_mdu        (id_mdu),
        .mdu_done      (mdu_done),
        .ex_mispredict (ex_mispredict),
        .imem_wait     (imem_wait),
        .dmem_wait     (dmem_wait),
        .stall_PC      (stall_PC),
        .stall_IFID    (stall_IFID),
        .flush_IFID    (flush_IFID),
        .flush_IDEX    (flush_IDEX),
        .issue         (issue),
        .busy_vec      (busy_vec),
        .stall_cause   (stall_cause)
    );

    typedef struct {
        string      name;
        bit         rst, valid;
        logic [4:0] rs, rt;
        bit         rsu, rtu;
        logic [4:0] dest;
        bit         wen;
        logic [2:0] lat;
        bit         mdu, done, mis, iw, dw;
        bit         e_st, e_fi, e_fx, e_iss;
        hz_cause_t  e_c;
        logic [31:0] e_busy;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] b(input int r);
        logic [31:0] one;
        one = 32'h1;
        return one << r;
    endfunction

    function automatic vec_t mk(input string nm, input bit rst, input bit valid,
                                input int rs, input int rt, input bit rsu, input bit rtu,
                                input int dest, input bit wen, input int lat,
                                input bit mdu, input bit done, input bit mis,
                                input bit iw, input bit dw,
                                input bit st, input bit fi, input bit fx, input bit iss,
                                input hz_cause_t c, input logic [31:0] busy);
        vec_t v;
        v.name = nm; v.rst = rst; v.valid = valid;
        v.rs = 5'(rs); v.rt = 5'(rt); v.rsu = rsu; v.rtu = rtu;
        v.dest = 5'(dest); v.wen = wen; v.lat = 3'(lat);
        v.mdu = mdu; v.done = done; v.mis = mis; v.iw = iw; v.dw = dw;
        v.e_st = st; v.e_fi = fi; v.e_fx = fx; v.e_iss = iss;
        v.e_c = c; v.e_busy = busy;
        return v;
    endfunction

    task automatic check1(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive on the falling edge, sample 1 ns later, well clear of the rising edge.
    task automatic apply(input vec_t v);
        @(negedge CLK);
        RST           = v.rst;
        id_valid      = v.valid;
        id_rs         = v.rs;
        id_rt         = v.rt;
        id_rs_used    = v.rsu;
        id_rt_used    = v.rtu;
        id_dest       = v.dest;
        id_wen        = v.wen;
        id_lat        = v.lat;
        id_mdu        = v.mdu;
        mdu_done      = v.done;
        ex_mispredict = v.mis;
        imem_wait     = v.iw;
        dmem_wait     = v.dw;
        #1;
        check1({v.name, ".stall_PC"},    32'(stall_PC),    32'(v.e_st));
        check1({v.name, ".stall_IFID"},  32'(stall_IFID),  32'(v.e_st));
        check1({v.name, ".flush_IFID"},  32'(flush_IFID),  32'(v.e_fi));
        check1({v.name, ".flush_IDEX"},  32'(flush_IDEX),  32'(v.e_fx));
        check1({v.name, ".issue"},       32'(issue),       32'(v.e_iss));
        check1({v.name, ".stall_cause"}, 32'(stall_cause), 32'(v.e_c));
        check1({v.name, ".busy_vec"},    busy_vec,         v.e_busy);
    endtask

    initial begin
        RST = 1'b1; id_valid = 0; id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0;
        id_dest = 0; id_wen = 0; id_lat = 0; id_mdu = 0; mdu_done = 0;
        ex_mispredict = 0; imem_wait = 0; dmem_wait = 0;
        #1;
        check1("reset.stall_PC",   32'(stall_PC),    32'd0);
        check1("reset.busy_vec",   busy_vec,         32'd0);
        check1("reset.cause",      32'(stall_cause), 32'(HZ_NONE));
        repeat (2) @(negedge CLK);

        //          name          rst val rs rt su tu dst wen lat mdu dn mis iw dw  st fi fx iss cause     busy
        // 1: reset in the middle of a RAW stall
        tbl.push_back(mk("t1_lw_r5",     0,1, 1,0,1,0, 5,1,3, 0,0,0,0,0, 0,0,0,1,HZ_NONE, 32'd0));
        tbl.push_back(mk("t1_raw_r5",    0,1, 5,0,1,0, 6,1,1, 0,0,0,0,0, 1,0,1,0,HZ_RAW,  b(5)));
        tbl.push_back(mk("t1_rst",       1,1, 5,0,1,0, 6,1,1, 0,0,0,0,0, 0,0,0,0,HZ_NONE, 32'd0));
        tbl.push_back(mk("t1_after_rst", 0,1, 5,0,1,0, 6,1,1, 0,0,0,0,0, 0,0,0,1,HZ_NONE, 32'd0));
        // 2: load-use costs one cycle; ALU back-to-back costs none
        tbl.push_back(mk("t2_lw_r3",     0,1, 1,0,1,0, 3,1,2, 0,0,0,0,0, 0,0,0,1,HZ_NONE, 32'd0));
        tbl.push_back(mk("t2_add_stall", 0,1, 3,3,1,1, 4,1,1, 0,0,0,0,0, 1,0,1,0,HZ_RAW,  b(3)));
        tbl.push_back(mk("t2_add_issue", 0,1, 3,3,1,1, 4,1,1, 0,0,0,0,0, 0,0,0,1,HZ_NONE, 32'd0));
        tbl.push_back(mk("alu_r7",       0,1, 1,0,1,0, 7,1,1, 0,0,0,0,0, 0,0,0,1,HZ_NONE, 32'd0));
        tbl.push_back(mk("alu_dep_r7",   0,1, 7,7,1,1, 0,0,1, 0,0,0,0,0, 0,0,0,1,HZ_NONE, 32'd0));
        // 3: MULT then DIV, structural stall until mdu_done
        tbl.push_back(mk("t3_mult",      0,1, 1,2,1,1, 8,1,1, 1,0,0,0,0, 0,0,0,1,HZ_NONE, 32'd0));
        tbl.push_back(mk("t3_div_stall1",0,1, 1,2,1,1,10,1,1, 1,0,0,0,0, 1,0,1,0,HZ_MDU,  b(8)));
        tbl.push_back(mk("t3_div_stall2",0,1, 1,2,1,1,10,1,1, 1,0,0,0,0, 1,0,1,0,HZ_MDU,  b(8)));
        tbl.push_back(mk("t3_div_done",  0,1, 1,2,1,1,10,1,1, 1,1,0,0,0, 0,0,0,1,HZ_NONE, b(8)));
        tbl.push_back(mk("t3_after_done",0,0, 0,0,0,0, 0,0,0, 0,0,0,0,0, 0,0,0,0,HZ_NONE, b(10)));
        tbl.push_back(mk("t3_div_fin",   0,0, 0,0,0,0, 0,0,0, 0,1,0,0,0, 0,0,0,0,HZ_NONE, b(10)));
        tbl.push_back(mk("t3_done_idle", 0,0, 0,0,0,0, 0,0,0, 0,1,0,0,0, 0,0,0,0,HZ_NONE, 32'd0));
        tbl.push_back(mk("t3_rd_r10",    0,1,10,0,1,0, 0,0,1, 0,0,0,0,0, 0,0,0,1,HZ_NONE, 32'd0));
        // 4: mispredict while frozen is deferred to the first unfrozen cycle
        tbl.push_back(mk("t4_frz_mis",   0,1, 1,0,1,0, 0,0,1, 0,0,1,0,1, 1,0,0,0,HZ_MEM,  32'd0));
        tbl.push_back(mk("t4_frz2",      0,1, 1,0,1,0, 0,0,1, 0,0,0,0,1, 1,0,0,0,HZ_MEM,  32'd0));
        tbl.push_back(mk("t4_frz3",      0,1, 1,0,1,0, 0,0,1, 0,0,0,0,1, 1,0,0,0,HZ_MEM,  32'd0));
        tbl.push_back(mk("t4_flush",     0,1, 1,0,1,0, 0,0,1, 0,0,0,0,0, 0,1,1,0,HZ_FLUSH,32'd0));
        tbl.push_back(mk("t4_after",     0,1, 1,0,1,0, 0,0,1, 0,0,0,0,0, 0,0,0,1,HZ_NONE, 32'd0));
        tbl.push_back(mk("t4_imem",      0,1, 1,0,1,0, 0,0,1, 0,0,0,1,0, 1,0,0,0,HZ_MEM,  32'd0));
        // 5: flush beats RAW and the squashed writer leaves r9 alone
        tbl.push_back(mk("t5_lw_r9",     0,1, 1,0,1,0, 9,1,4, 0,0,0,0,0, 0,0,0,1,HZ_NONE, 32'd0));
        tbl.push_back(mk("t5_raw_mis",   0,1, 9,0,1,0, 9,1,1, 0,0,1,0,0, 0,1,1,0,HZ_FLUSH,b(9)));
        tbl.push_back(mk("t5_bubble",    0,0, 0,0,0,0, 0,0,0, 0,0,0,0,0, 0,0,0,0,HZ_NONE, b(9)));
        tbl.push_back(mk("t5_raw_r9",    0,1, 9,0,1,0,14,1,1, 0,0,0,0,0, 1,0,1,0,HZ_RAW,  b(9)));
        tbl.push_back(mk("t5_issue_r9",  0,1, 9,0,1,0,14,1,1, 0,0,0,0,0, 0,0,0,1,HZ_NONE, 32'd0));
        // 6: r0 is never pending
        tbl.push_back(mk("t6_wr_r0",     0,1, 1,0,1,0, 0,1,4, 0,0,0,0,0, 0,0,0,1,HZ_NONE, 32'd0));
        tbl.push_back(mk("t6_rd_r0",     0,1, 0,0,1,1, 0,0,1, 0,0,0,0,0, 0,0,0,1,HZ_NONE, 32'd0));
        // WAW: short write behind a long one to r11
        tbl.push_back(mk("waw_lw_r11",   0,1, 1,0,1,0,11,1,4, 0,0,0,0,0, 0,0,0,1,HZ_NONE, 32'd0));
        tbl.push_back(mk("waw_stall1",   0,1, 1,0,1,0,11,1,1, 0,0,0,0,0, 1,0,1,0,HZ_WAW,  b(11)));
        tbl.push_back(mk("waw_stall2",   0,1, 1,0,1,0,11,1,1, 0,0,0,0,0, 1,0,1,0,HZ_WAW,  b(11)));
        tbl.push_back(mk("waw_stall3",   0,1, 1,0,1,0,11,1,1, 0,0,0,0,0, 1,0,1,0,HZ_WAW,  b(11)));
        tbl.push_back(mk("waw_issue",    0,1, 1,0,1,0,11,1,1, 0,0,0,0,0, 0,0,0,1,HZ_NONE, 32'd0));
        // lat 0 means MAX_LAT; freeze holds the counter
        tbl.push_back(mk("lat0_lw_r12",  0,1, 1,0,1,0,12,1,0, 0,0,0,0,0, 0,0,0,1,HZ_NONE, 32'd0));
        tbl.push_back(mk("frz_hold",     0,1,12,0,1,0, 0,0,1, 0,0,0,0,1, 1,0,0,0,HZ_MEM,  b(12)));
        tbl.push_back(mk("r12_raw1",     0,1,12,0,1,0, 0,0,1, 0,0,0,0,0, 1,0,1,0,HZ_RAW,  b(12)));
        tbl.push_back(mk("r12_raw2",     0,1,12,0,1,0, 0,0,1, 0,0,0,0,0, 1,0,1,0,HZ_RAW,  b(12)));
        tbl.push_back(mk("r12_raw3",     0,1,12,0,1,0, 0,0,1, 0,0,0,0,0, 1,0,1,0,HZ_RAW,  b(12)));
        tbl.push_back(mk("r12_issue",    0,1,12,0,1,0, 0,0,1, 0,0,0,0,0, 0,0,0,1,HZ_NONE, 32'd0));

        foreach (tbl[i]) apply(tbl[i]);

        // Hand sequence: mdu_done during a freeze still retires the MDU op.
        apply(mk("h_mult_r13",   0,1, 1,2,1,1,13,1,1, 1,0,0,0,0, 0,0,0,1,HZ_NONE, 32'd0));
        apply(mk("h_frz_done",   0,0, 0,0,0,0, 0,0,0, 0,1,0,0,1, 1,0,0,0,HZ_MEM,  b(13)));
        check1("h_frz_done.issue_gated", 32'(issue), 32'd0);
        apply(mk("h_mdu_free",   0,1, 1,2,1,1, 0,0,1, 1,0,0,0,0, 0,0,0,1,HZ_NONE, 32'd0));
        // MDU op with no destination: unit busy, but no register marked pending.
        apply(mk("h_nodest",     0,1, 3,0,1,0, 0,0,1, 0,0,0,0,0, 0,0,0,1,HZ_NONE, 32'd0));
        apply(mk("h_mdu_struct", 0,1, 1,2,1,1, 0,0,1, 1,0,0,0,0, 1,0,1,0,HZ_MDU,  32'd0));
        apply(mk("h_mdu_retire", 0,0, 0,0,0,0, 0,0,0, 0,1,0,0,0, 0,0,0,0,HZ_NONE, 32'd0));
        apply(mk("h_mdu_again",  0,1, 1,2,1,1, 0,0,1, 1,0,0,0,0, 0,0,0,1,HZ_NONE, 32'd0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
